// File: rtl/aon_apb_slave_if.sv
// APB3 slave front-end for the always-on power-controller register file.
// Each APB transfer becomes one valid/ready request. Range, alignment and timeout failures are returned on pslverr.
module aon_apb_slave_if #(
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] ADDR_MAX       = 'h1C,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  i_aon_clk,
  input  logic                  i_soc_pwr_on_rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  slv_o_valid,
  output logic [DATA_WIDTH-1:0] slv_o_addr,
  output logic [DATA_WIDTH-1:0] slv_o_wr_data,
  output logic                  slv_o_rd0_wr1,
  input  logic                  slv_i_ready,
  input  logic [DATA_WIDTH-1:0] slv_i_rd_data,
  input  logic                  slv_i_rd_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state;
  logic [7:0]            r_cnt, w_cnt;
  logic                  r_valid, w_valid;
  logic [DATA_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic                  r_wr, w_wr;
  logic                  r_pready, w_pready;
  logic                  r_pslverr, w_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata;

  logic w_setup;
  logic w_accept;
  logic w_bad_addr;

  assign w_setup    = psel & ~penable;
  assign w_accept   = r_valid & slv_i_ready;
  assign w_bad_addr = (paddr > ADDR_MAX) | (paddr[1:0] != 2'b00);

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_valid   = r_valid;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_wr      = r_wr;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    w_prdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          if (w_bad_addr) begin
            // Local error: answer without ever touching the register file.
            w_state   = S_RESP;
            w_pready  = 1'b1;
            w_pslverr = 1'b1;
          end else begin
            w_addr  = paddr;
            w_wdata = pwdata;
            w_wr    = pwrite;
            w_valid = 1'b1;
            w_cnt   = '0;
            w_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A completed handshake wins over abort and timeout: the register file already acted.
        if (w_accept) begin
          w_valid  = 1'b0;
          w_state  = S_RESP;
          w_pready = 1'b1;
          if (!r_wr) begin
            if (slv_i_rd_valid) begin
              w_prdata = slv_i_rd_data;
            end else begin
              w_pslverr = 1'b1;
            end
          end
        end else if (!psel) begin
          w_valid = 1'b0;
          w_state = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_valid   = 1'b0;
          w_state   = S_RESP;
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_aon_clk) begin
    if (i_soc_pwr_on_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wr      <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_valid   <= w_valid;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_wr      <= w_wr;
      r_pready  <= w_pready;
      r_pslverr <= w_pslverr;
      r_prdata  <= w_prdata;
    end
  end

  assign pready        = r_pready;
  assign pslverr       = r_pslverr;
  assign prdata        = r_prdata;
  assign slv_o_valid   = r_valid;
  assign slv_o_addr    = r_addr;
  assign slv_o_wr_data = r_wdata;
  assign slv_o_rd0_wr1 = r_wr;

endmodule

// File: tb/tb_aon_apb_slave_if.sv
// Bench for aon_apb_slave_if: transaction-level expectations are expanded into a per-cycle timeline.
// Every cycle is compared against that timeline, and some directed cases are pinned to literal values.
module tb_aon_apb_slave_if;

  localparam int          TO   = 16;
  localparam logic [31:0] AMAX = 32'h1C;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        slv_o_valid;
  logic [31:0] slv_o_addr;
  logic [31:0] slv_o_wr_data;
  logic        slv_o_rd0_wr1;
  logic        slv_i_ready;
  logic [31:0] slv_i_rd_data;
  logic        slv_i_rd_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 0;

  logic        exp_valid   = 1'b0;
  logic        exp_pready  = 1'b0;
  logic        exp_pslverr = 1'b0;
  logic        exp_wr      = 1'b0;
  logic [31:0] exp_prdata  = '0;
  logic [31:0] exp_addr    = '0;
  logic [31:0] exp_wdata   = '0;

  int          seen_pready_cyc = -1;
  logic [31:0] seen_prdata     = '0;
  logic        seen_err        = 1'b0;
  int          valid_total     = 0;

  aon_apb_slave_if #(
    .DATA_WIDTH    (32),
    .ADDR_MAX      (AMAX),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_aon_clk       (clk),
    .i_soc_pwr_on_rst(rst),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .pready          (pready),
    .prdata          (prdata),
    .pslverr         (pslverr),
    .slv_o_valid     (slv_o_valid),
    .slv_o_addr      (slv_o_addr),
    .slv_o_wr_data   (slv_o_wr_data),
    .slv_o_rd0_wr1   (slv_o_rd0_wr1),
    .slv_i_ready     (slv_i_ready),
    .slv_i_rd_data   (slv_i_rd_data),
    .slv_i_rd_valid  (slv_i_rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (slv_o_valid === 1'b1) valid_total++;
    if (pready === 1'b1) begin
      seen_pready_cyc = cyc;
      seen_prdata     = prdata;
      seen_err        = pslverr;
    end
    if (chk_en) begin
      chk("slv_o_valid", 32'(slv_o_valid), 32'(exp_valid));
      chk("pready", 32'(pready), 32'(exp_pready));
      chk("pslverr", 32'(pslverr), 32'(exp_pslverr));
      chk("prdata", prdata, exp_prdata);
      if (exp_valid) begin
        chk("slv_o_addr", slv_o_addr, exp_addr);
        chk("slv_o_wr_data", slv_o_wr_data, exp_wdata);
        chk("slv_o_rd0_wr1", 32'(slv_o_rd0_wr1), 32'(exp_wr));
      end
    end
  end

  task automatic set_idle_exp();
    exp_valid   = 1'b0;
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = '0;
  endtask

  task automatic noise_rf();
    slv_i_ready    = 1'($urandom);
    slv_i_rd_valid = 1'($urandom);
    slv_i_rd_data  = $urandom;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      psel    = 1'b0;
      penable = 1'b0;
      noise_rf();
      set_idle_exp();
      @(posedge clk); #1;
    end
  endtask

  // delay = REQ cycles with ready low before the accepting cycle; delay >= TO never accepts.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      input int delay, input bit rdv, input logic [31:0] rdd,
                      output int lat, output int nvalid,
                      output logic [31:0] got_rd, output logic got_err);
    bit bad;
    bit tmo;
    int nreq;
    int c0;
    int v0;
    bad  = (addr > AMAX) || (addr[1:0] != 2'b00);
    tmo  = !bad && (delay >= TO);
    nreq = bad ? 0 : (tmo ? TO : delay + 1);

    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    noise_rf();
    set_idle_exp();
    c0 = cyc;
    v0 = valid_total;
    @(posedge clk); #1;

    penable = 1'b1;
    for (int j = 0; j < nreq; j++) begin
      slv_i_ready    = (j == delay);
      slv_i_rd_valid = (j == delay) ? rdv : 1'($urandom);
      slv_i_rd_data  = (j == delay) ? rdd : $urandom;
      exp_valid   = 1'b1;
      exp_addr    = addr;
      exp_wdata   = wd;
      exp_wr      = wr;
      exp_pready  = 1'b0;
      exp_pslverr = 1'b0;
      exp_prdata  = '0;
      @(posedge clk); #1;
    end

    noise_rf();
    exp_valid   = 1'b0;
    exp_pready  = 1'b1;
    exp_pslverr = bad || tmo || (!wr && !rdv);
    exp_prdata  = (!bad && !tmo && !wr && rdv) ? rdd : 32'h0;
    @(posedge clk); #1;

    lat     = (seen_pready_cyc >= c0) ? (seen_pready_cyc - c0) : -1;
    nvalid  = valid_total - v0;
    got_rd  = seen_prdata;
    got_err = seen_err;
    psel    = 1'b0;
    penable = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    int          lat;
    int          nv;
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          d;
    int          sel;
    bit          w;
    bit          rv;

    rst            = 1'b1;
    psel           = 1'b0;
    penable        = 1'b0;
    pwrite         = 1'b0;
    paddr          = '0;
    pwdata         = '0;
    slv_i_ready    = 1'b0;
    slv_i_rd_valid = 1'b0;
    slv_i_rd_data  = '0;

    // Reset state, with register-file inputs toggling to show that reset dominates.
    @(posedge clk); #1;
    set_idle_exp();
    chk_en = 1;
    psel = 1'b1;
    paddr = 32'h10;
    noise_rf();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_addr", slv_o_addr, 32'h0);
    chk("rst_wdata", slv_o_wr_data, 32'h0);
    chk("rst_dir", 32'(slv_o_rd0_wr1), 32'h0);
    @(posedge clk); #1;
    rst  = 1'b0;
    psel = 1'b0;
    idle(2);

    // Write with ready tied high: one wait state.
    xfer(1'b1, 32'h10, 32'h5, 0, 1'b1, 32'h0, lat, nv, rd, er);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_nvalid", 32'(nv), 32'd1);
    chk("t1_err", 32'(er), 32'd0);
    idle(1);

    // Read returns register data.
    xfer(1'b0, 32'h18, 32'h0, 0, 1'b1, 32'hA5, lat, nv, rd, er);
    chk("t2_lat", 32'(lat), 32'd2);
    chk("t2_rdata", rd, 32'hA5);
    chk("t2_err", 32'(er), 32'd0);
    idle(1);

    // Misaligned and out-of-range addresses are errored locally.
    xfer(1'b1, 32'h06, 32'h1, 0, 1'b1, 32'h0, lat, nv, rd, er);
    chk("t3a_lat", 32'(lat), 32'd1);
    chk("t3a_nvalid", 32'(nv), 32'd0);
    chk("t3a_err", 32'(er), 32'd1);
    xfer(1'b0, 32'h20, 32'h0, 0, 1'b1, 32'h77, lat, nv, rd, er);
    chk("t3b_lat", 32'(lat), 32'd1);
    chk("t3b_nvalid", 32'(nv), 32'd0);
    chk("t3b_rdata", rd, 32'h0);
    chk("t3b_err", 32'(er), 32'd1);
    xfer(1'b0, 32'h0C, 32'h0, 0, 1'b0, 32'h5A, lat, nv, rd, er);
    chk("t3c_rdata", rd, 32'h0);
    chk("t3c_err", 32'(er), 32'd1);
    idle(1);

    // Ready never arrives: sixteen request cycles, then an error response.
    xfer(1'b1, 32'h08, 32'h33, 1000, 1'b1, 32'h0, lat, nv, rd, er);
    chk("t4_nvalid", 32'(nv), 32'd16);
    chk("t4_lat", 32'(lat), 32'd17);
    chk("t4_err", 32'(er), 32'd1);
    idle(1);

    // Ready arrives in the fourth request cycle.
    xfer(1'b1, 32'h04, 32'hDEAD, 3, 1'b1, 32'h0, lat, nv, rd, er);
    chk("t5_nvalid", 32'(nv), 32'd4);
    chk("t5_lat", 32'(lat), 32'd5);
    chk("t5_err", 32'(er), 32'd0);
    idle(1);

    // Reset during a request: the request drops and no response follows.
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h08;
    pwdata  = 32'h77;
    slv_i_ready = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
    penable   = 1'b1;
    exp_valid = 1'b1;
    exp_addr  = 32'h08;
    exp_wdata = 32'h77;
    exp_wr    = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    set_idle_exp();
    @(negedge clk);
    chk("t6_rst_addr", slv_o_addr, 32'h0);
    chk("t6_rst_wdata", slv_o_wr_data, 32'h0);
    @(posedge clk); #1;
    idle(3);
    xfer(1'b1, 32'h00, 32'h11, 0, 1'b1, 32'h0, lat, nv, rd, er);
    chk("t6_post_lat", 32'(lat), 32'd2);
    chk("t6_post_err", 32'(er), 32'd0);

    // Back-to-back write then read, no idle between.
    xfer(1'b1, 32'h00, 32'h22, 0, 1'b1, 32'h0, lat, nv, rd, er);
    chk("t6_b2b_wr_lat", 32'(lat), 32'd2);
    xfer(1'b0, 32'h00, 32'h0, 0, 1'b1, 32'h3C, lat, nv, rd, er);
    chk("t6_b2b_rd_lat", 32'(lat), 32'd2);
    chk("t6_b2b_rdata", rd, 32'h3C);

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 40; i++) begin
      w   = 1'($urandom);
      rv  = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       a = ($urandom_range(0, 7) << 2) | $urandom_range(1, 3);
        1:       a = 32'h20 + ($urandom_range(0, 60) << 2);
        2:       a = $urandom | 32'h100;
        default: a = $urandom_range(0, 7) << 2;
      endcase
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      d = int'($urandom_range(16, 20));
      else if (sel == 1) d = 15;
      else               d = int'($urandom_range(0, 4));
      xfer(w, a, $urandom, d, rv, $urandom, lat, nv, rd, er);
      sel = int'($urandom_range(0, 2));
      if (sel != 0) idle(sel);
    end

    idle(3);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aon_apb_slave_if.md
Name: aon_apb_slave_if

Overview:
- APB3 slave front-end for the always-on power-controller register file.
- Terminates APB transfers from the SoC interconnect and converts each one into a single valid/ready request on the register-file side interface (slv_o_* / slv_i_*).
- Returns read data and completion to the APB master.
- Checks address range and alignment, detects register-file timeout, and reports failures through PSLVERR.

Parameters:
- DATA_WIDTH, 32, APB data and address width; also the width of the register-file side buses.
- ADDR_MAX, 32'h1C, highest legal word address; higher addresses are errored locally.
- TIMEOUT_CYCLES, 16, maximum REQ cycles spent waiting for slv_i_ready before the transfer is errored (range 1..255).

Ports:
- i_aon_clk  in  1  always-on clock
- i_soc_pwr_on_rst  in  1  synchronous active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  APB direction (1 = write)
- paddr  in  DATA_WIDTH  APB address
- pwdata  in  DATA_WIDTH  APB write data
- pready  out  1  APB transfer complete
- prdata  out  DATA_WIDTH  APB read data
- pslverr  out  1  APB error, valid only while pready=1
- slv_o_valid  out  1  request valid to register file
- slv_o_addr  out  DATA_WIDTH  request address
- slv_o_wr_data  out  DATA_WIDTH  request write data
- slv_o_rd0_wr1  out  1  request direction (0 = read, 1 = write)
- slv_i_ready  in  1  register file accepts the request
- slv_i_rd_data  in  DATA_WIDTH  read data; combinational, valid in the accept cycle
- slv_i_rd_valid  in  1  read data valid, qualified by slv_o_valid and slv_i_ready

Behaviour:
- Single clock: i_aon_clk.
- Reset is synchronous, active-high (i_soc_pwr_on_rst sampled on i_aon_clk rising edge). It dominates all other inputs.
- Reset values: FSM=IDLE; all outputs 0; timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, REQ, RESP.

IDLE:
- Waits for a setup phase: psel=1, penable=0.
- On setup, capture paddr, pwdata and pwrite.
- If paddr>ADDR_MAX or paddr[1:0]!=0:
  - Go to RESP with pslverr=1 and prdata=0.
  - Never assert slv_o_valid.
- Otherwise:
  - Drive slv_o_addr, slv_o_wr_data and slv_o_rd0_wr1 from the captured values.
  - Set slv_o_valid=1, clear the timeout counter, and go to REQ.

REQ:
- slv_o_valid and the request fields are held stable until accepted.
- Accept (slv_o_valid & slv_i_ready):
  - Clear slv_o_valid and go to RESP.
  - Write: pslverr=0, prdata=0.
  - Read with slv_i_rd_valid=1: prdata=slv_i_rd_data, pslverr=0.
  - Read with slv_i_rd_valid=0: prdata=0, pslverr=1.
- No accept: increment the counter.
- When the counter reaches TIMEOUT_CYCLES-1 without accept: clear slv_o_valid, go to RESP with pslverr=1, prdata=0.
- psel=0 in REQ is a protocol abort: clear slv_o_valid, pready=0, go to IDLE.

RESP:
- pready=1 for exactly one cycle. The master completes on psel&penable&pready.
- Next cycle: pready=0, pslverr=0, prdata=0, go to IDLE.

Timing:
- Latency with slv_i_ready tied 1: setup at cycle T, REQ at T+1 (slv_o_valid=1), pready at T+2. This is one APB wait state.
- Local error: pready at T+1, i.e. zero wait states.
- Back-to-back: a new setup phase is accepted in the cycle after RESP; no extra idle is required.

Other rules:
- pready is never asserted outside RESP.
- slv_o_valid is never high in IDLE or RESP.
- At most one request is outstanding at a time.
- A setup phase seen while in REQ or RESP is ignored.
- Reset asserted mid-REQ: slv_o_valid drops on the next edge; no response is issued.

Test Plan:
1. Write paddr=0x10, pwdata=0x5, slv_i_ready=1 -> slv_o_valid=1 for 1 cycle (T+1) with addr 0x10, data 0x5, rd0_wr1=1; pready=1 at T+2, pslverr=0.
2. Read paddr=0x18, register file returns rd_data=0xA5 with rd_valid=1 -> slv_o_rd0_wr1=0; prdata=0xA5 with pready at T+2, pslverr=0.
3. Local errors:
   - paddr=0x06 -> no slv_o_valid; pready=1 at T+1, pslverr=1, prdata=0.
   - paddr=0x20 -> no slv_o_valid; pready=1 at T+1, pslverr=1, prdata=0.
   - Read where rd_valid=0 at accept -> pslverr=1, prdata=0.
4. slv_i_ready held 0 -> slv_o_valid high for exactly 16 cycles then drops; pready=1 with pslverr=1 on the following cycle.
5. slv_i_ready low for 3 cycles then high on write paddr=0x04 -> request fields stable all 4 cycles; pready one cycle after accept, pslverr=0.
6. Reset and back-to-back:
   - Assert reset during REQ -> next cycle all outputs 0, FSM IDLE; a following write to 0x00 completes normally.
   - Back-to-back write 0x00 then read 0x00 with no idle -> both complete with 1 wait state each.
